// File: rtl/chan_pkg.sv
// rtl/chan_pkg.sv - shared header layout, FSM encodings and block sizing for chan_arbiter
package chan_pkg;

    // Block header layout: 1M NNNNNN LLLLLLLL
    localparam int HDR_VALID  = 15;
    localparam int HDR_MASTER = 14;
    localparam int HDR_CH_HI  = 13;
    localparam int HDR_CH_LO  = 8;
    localparam int HDR_LEN_HI = 7;
    localparam int HDR_LEN_LO = 0;

    // Largest block is a master block with L=255: header + trigger + 255 data.
    localparam int MAX_BLOCK = 257;
    localparam int CNT_W     = $clog2(MAX_BLOCK + 1);

    typedef enum logic [3:0] {
        ST_IDLE = 4'b0001,
        ST_HEAD = 4'b0010,
        ST_SKIP = 4'b0100,
        ST_COPY = 4'b1000
    } state_e;

    // Total words in a block, header included.
    function automatic logic [CNT_W-1:0] block_words(input logic [15:0] hdr);
        logic [CNT_W-1:0] len;
        len = {1'b0, hdr[HDR_LEN_HI:HDR_LEN_LO]};
        return hdr[HDR_MASTER] ? len + CNT_W'(2) : len + CNT_W'(1);
    endfunction

    // Channel number field; carried through untouched by the arbiter.
    function automatic logic [5:0] hdr_chan(input logic [15:0] hdr);
        return hdr[HDR_CH_HI:HDR_CH_LO];
    endfunction

endpackage

// File: rtl/chan_arbiter_if.sv
// rtl/chan_arbiter_if.sv - channel-side and readout-side signals of chan_arbiter
// Ports (as signals):
//   req[NCH], din[16*NCH] : channel requests and flattened channel words
//   ack[NCH]              : one-hot word acknowledge back to the channels
//   dout, dvalid, ofull   : merged word stream and downstream almost-full
//   busy, herr            : block in progress, sticky bad-header flag
interface chan_arbiter_if #(
    parameter int NCH = 16
);
    logic [NCH-1:0]    req;
    logic [16*NCH-1:0] din;
    logic [NCH-1:0]    ack;
    logic [15:0]       dout;
    logic              dvalid;
    logic              ofull;
    logic              busy;
    logic              herr;

    modport master (
        input  req, din, ofull,
        output ack, dout, dvalid, busy, herr
    );

    modport slave (
        output req, din, ofull,
        input  ack, dout, dvalid, busy, herr
    );
endinterface

// File: rtl/chan_arbiter_rr_pick.sv
// rtl/chan_arbiter_rr_pick.sv - combinational round-robin priority encoder
// Ports:
//   req   : per-channel request vector
//   ptr   : last granted channel; search starts at ptr+1 and wraps
//   grant : index of first requester after ptr
//   any   : at least one request present
module rr_pick #(
    parameter int NCH = 16,
    parameter int PW  = 4
) (
    input  logic [NCH-1:0] req,
    input  logic [PW-1:0]  ptr,
    output logic [PW-1:0]  grant,
    output logic           any
);

    // Scan from farthest to nearest so the nearest requester after ptr
    // is the last one written and therefore wins.
    always_comb begin
        int          idx;
        logic [PW-1:0] sel;
        grant = '0;
        any   = 1'b0;
        idx   = 0;
        sel   = '0;
        for (int i = NCH; i >= 1; i--) begin
            idx = int'(ptr) + i;
            if (idx >= NCH) begin
                idx = idx - NCH;
            end
            sel = PW'(idx);
            if (req[sel]) begin
                any   = 1'b1;
                grant = sel;
            end
        end
    end

endmodule

// File: rtl/chan_arbiter.sv
// rtl/chan_arbiter.sv - round-robin block arbiter merging NCH channel streams
// Ports:
//   clk, reset : system clock, synchronous active-high reset
//   bus        : chan_arbiter_if master (req/din/ack to channels,
//                dout/dvalid/ofull to readout, busy/herr status)
module chan_arbiter
    import chan_pkg::*;
#(
    parameter int NCH          = 16,
    parameter int OFULL_MARGIN = 258
) (
    input logic             clk,
    input logic             reset,
    chan_arbiter_if.master  bus
);

    localparam int PW = (NCH > 1) ? $clog2(NCH) : 1;

    if (NCH < 1 || NCH > 64) begin : g_bad_nch
        $error("chan_arbiter: NCH out of range");
    end
    if (OFULL_MARGIN < MAX_BLOCK + 1) begin : g_bad_margin
        $error("chan_arbiter: OFULL_MARGIN smaller than largest block");
    end

    state_e           state_q, state_d;
    logic [PW-1:0]    ptr_q, ptr_d;
    logic [NCH-1:0]   ack_q, ack_d;
    logic [15:0]      dout_q, dout_d;
    logic             dvalid_q, dvalid_d;
    logic             busy_q, busy_d;
    logic             herr_q, herr_d;
    logic [CNT_W-1:0] wlen_q, wlen_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic [PW-1:0]    pick_idx;
    logic             pick_any;
    logic [15:0]      din_arr [NCH];
    logic [15:0]      din_g;
    logic [CNT_W-1:0] hdr_w;

    for (genvar i = 0; i < NCH; i++) begin : g_din
        assign din_arr[i] = bus.din[16*i +: 16];
    end

    // ptr_q doubles as the granted channel while a block is in flight.
    assign din_g = din_arr[ptr_q];
    assign hdr_w = block_words(din_g);

    rr_pick #(
        .NCH (NCH),
        .PW  (PW)
    ) u_rr_pick (
        .req   (bus.req),
        .ptr   (ptr_q),
        .grant (pick_idx),
        .any   (pick_any)
    );

    always_comb begin
        state_d  = state_q;
        ptr_d    = ptr_q;
        ack_d    = '0;
        dout_d   = dout_q;
        dvalid_d = 1'b0;
        busy_d   = busy_q;
        herr_d   = herr_q;
        wlen_d   = wlen_q;
        cnt_d    = cnt_q;

        unique case (state_q)
            ST_IDLE: begin
                // Downstream space is only checked here; a whole block
                // always fits once ofull is low.
                if (!bus.ofull && pick_any) begin
                    ack_d[pick_idx] = 1'b1;
                    ptr_d           = pick_idx;
                    busy_d          = 1'b1;
                    state_d         = ST_HEAD;
                end
            end
            ST_HEAD: begin
                if (!din_g[HDR_VALID]) begin
                    herr_d  = 1'b1;
                    busy_d  = 1'b0;
                    state_d = ST_IDLE;
                end else begin
                    wlen_d   = hdr_w;
                    dout_d   = din_g;
                    dvalid_d = 1'b1;
                    if (hdr_w == CNT_W'(1)) begin
                        busy_d  = 1'b0;
                        state_d = ST_IDLE;
                    end else begin
                        ack_d[ptr_q] = 1'b1;
                        state_d      = ST_SKIP;
                    end
                end
            end
            ST_SKIP: begin
                // din still shows the header this cycle (channel read latency).
                cnt_d = wlen_q - CNT_W'(1);
                if (wlen_q > CNT_W'(2)) begin
                    ack_d[ptr_q] = 1'b1;
                end
                state_d = ST_COPY;
            end
            ST_COPY: begin
                dout_d   = din_g;
                dvalid_d = 1'b1;
                cnt_d    = cnt_q - CNT_W'(1);
                // Two acks are still in flight ahead of the capture point,
                // so stop acking once only two words remain to be captured.
                if (cnt_q > CNT_W'(2)) begin
                    ack_d[ptr_q] = 1'b1;
                end
                if (cnt_q == CNT_W'(1)) begin
                    busy_d  = 1'b0;
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            ptr_q    <= PW'(NCH - 1);
            ack_q    <= '0;
            dout_q   <= '0;
            dvalid_q <= 1'b0;
            busy_q   <= 1'b0;
            herr_q   <= 1'b0;
            wlen_q   <= '0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            ptr_q    <= ptr_d;
            ack_q    <= ack_d;
            dout_q   <= dout_d;
            dvalid_q <= dvalid_d;
            busy_q   <= busy_d;
            herr_q   <= herr_d;
            wlen_q   <= wlen_d;
            cnt_q    <= cnt_d;
        end
    end

    assign bus.ack    = ack_q;
    assign bus.dout   = dout_q;
    assign bus.dvalid = dvalid_q;
    assign bus.busy   = busy_q;
    assign bus.herr   = herr_q;

endmodule

// File: tb/tb_chan_arbiter.sv
// tb/tb_chan_arbiter.sv - scoreboard bench for chan_arbiter with channel FIFO models
module tb_chan_arbiter;

    localparam int NCH   = 16;
    localparam int DEPTH = 1024;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #4 clk = ~clk;

    chan_arbiter_if #(.NCH(NCH)) bus ();

    chan_arbiter #(
        .NCH          (NCH),
        .OFULL_MARGIN (258)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int checks = 0;
    int errors = 0;

    logic [15:0] mem [NCH][DEPTH];
    int          wr_cnt [NCH];
    int          rp [NCH];
    logic [15:0] ch_din [NCH];

    logic [15:0] sb [$];
    int          grant_q [$];
    int          len_q [$];
    int          run_len;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    function automatic int blk_words(input logic [15:0] h);
        return int'(h[7:0]) + (h[14] ? 2 : 1);
    endfunction

    function automatic int onehot_idx(input logic [NCH-1:0] v);
        for (int i = 0; i < NCH; i++) begin
            if (v[i]) return i;
        end
        return -1;
    endfunction

    // Channel model: ack advances the read pointer, din follows one edge later.
    always @(posedge clk) begin
        for (int i = 0; i < NCH; i++) begin
            if (reset) begin
                rp[i]     <= 0;
                ch_din[i] <= 16'h0000;
            end else begin
                ch_din[i] <= mem[i][rp[i] % DEPTH];
                rp[i]     <= rp[i] + (bus.ack[i] ? 1 : 0);
            end
        end
    end

    always_comb begin
        bus.req = '0;
        bus.din = '0;
        for (int i = 0; i < NCH; i++) begin
            bus.req[i]         = (wr_cnt[i] - rp[i]) >= 2;
            bus.din[16*i +: 16] = ch_din[i];
        end
    end

    // Monitor: scoreboard compare, ack one-hot, grant/ack-run recording.
    initial begin
        run_len = 0;
        forever begin
            @(negedge clk);
            if (reset) begin
                run_len = 0;
            end else begin
                if (bus.dvalid) begin
                    if (sb.size() == 0) check_eq("dvalid_unexpected", 32'(bus.dvalid), 32'd0);
                    else check_eq("dout", 32'(bus.dout), 32'(sb.pop_front()));
                end
                if (bus.ack != '0) begin
                    check_eq("ack_onehot", 32'($countones(bus.ack)), 32'd1);
                    if (run_len == 0) grant_q.push_back(onehot_idx(bus.ack));
                    run_len++;
                end else if (run_len != 0) begin
                    len_q.push_back(run_len);
                    run_len = 0;
                end
            end
        end
    end

    task automatic put(input int ch, input logic [15:0] w);
        mem[ch][wr_cnt[ch] % DEPTH] = w;
        wr_cnt[ch]++;
    endtask

    task automatic load_block(input int ch, input logic [15:0] hdr, input logic [15:0] base);
        int w;
        w = blk_words(hdr);
        put(ch, hdr);
        for (int k = 1; k < w; k++) put(ch, base + 16'(k));
    endtask

    task automatic expect_block(input logic [15:0] hdr, input logic [15:0] base);
        int w;
        w = blk_words(hdr);
        sb.push_back(hdr);
        for (int k = 1; k < w; k++) sb.push_back(base + 16'(k));
    endtask

    task automatic wait_ack(input int ch, input string tag);
        int n;
        n = 0;
        while (bus.ack[ch] !== 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) check_eq(tag, 32'(bus.ack), 32'(1 << ch));
    endtask

    task automatic drain(input string tag);
        int n;
        n = 0;
        while ((sb.size() != 0 || bus.busy || bus.ack != '0) && n < 2000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 2000) check_eq(tag, 32'(sb.size()), 32'd0);
        repeat (2) @(negedge clk);
    endtask

    task automatic expect_run(input string tag, input int ch, input int len);
        if (grant_q.size() == 0) check_eq({tag, "_grant"}, 32'(grant_q.size()), 32'd1);
        else check_eq({tag, "_grant"}, 32'(grant_q.pop_front()), 32'(ch));
        if (len_q.size() == 0) check_eq({tag, "_acklen"}, 32'(len_q.size()), 32'd1);
        else check_eq({tag, "_acklen"}, 32'(len_q.pop_front()), 32'(len));
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [NCH-1:0] acc;
        logic [15:0]    dv_pat [8];
        for (int i = 0; i < NCH; i++) wr_cnt[i] = 0;
        bus.ofull = 1'b0;
        reset = 1'b1;
        repeat (3) @(negedge clk);

        check_eq("rst_ack", 32'(bus.ack), 32'd0);
        check_eq("rst_dout", 32'(bus.dout), 32'd0);
        check_eq("rst_dvalid", 32'(bus.dvalid), 32'd0);
        check_eq("rst_busy", 32'(bus.busy), 32'd0);
        check_eq("rst_herr", 32'(bus.herr), 32'd0);
        reset = 1'b0;
        @(negedge clk);

        // Round robin from reset pointer NCH-1: order 0,3,0,3
        load_block(0, 16'h8001, 16'hA000);
        load_block(0, 16'h8001, 16'hA100);
        load_block(3, 16'h8301, 16'hB000);
        load_block(3, 16'h8301, 16'hB100);
        expect_block(16'h8001, 16'hA000);
        expect_block(16'h8301, 16'hB000);
        expect_block(16'h8001, 16'hA100);
        expect_block(16'h8301, 16'hB100);
        drain("rr_drain");
        expect_run("rr0", 0, 2);
        expect_run("rr1", 3, 2);
        expect_run("rr2", 0, 2);
        expect_run("rr3", 3, 2);

        // Self-trigger block on channel 3, dvalid pattern 1,0,1,1,1,1,1
        dv_pat = '{16'd0, 16'd1, 16'd0, 16'd1, 16'd1, 16'd1, 16'd1, 16'd1};
        load_block(3, 16'h8305, 16'h3000);
        expect_block(16'h8305, 16'h3000);
        wait_ack(3, "st_ack_timeout");
        check_eq("st_c0_dvalid", 32'(bus.dvalid), 32'(dv_pat[0]));
        check_eq("st_c0_busy", 32'(bus.busy), 32'd1);
        for (int k = 1; k < 8; k++) begin
            @(negedge clk);
            check_eq($sformatf("st_c%0d_dvalid", k), 32'(bus.dvalid), 32'(dv_pat[k]));
            check_eq($sformatf("st_c%0d_busy", k), 32'(bus.busy), (k <= 6) ? 32'd1 : 32'd0);
        end
        drain("st_drain");
        expect_run("st", 3, 6);

        // Master block on channel 0
        put(0, 16'hC002); put(0, 16'h8ABC); put(0, 16'h0011); put(0, 16'h0022);
        sb.push_back(16'hC002); sb.push_back(16'h8ABC);
        sb.push_back(16'h0011); sb.push_back(16'h0022);
        drain("mt_drain");
        expect_run("mt", 0, 4);

        // Largest block: master, L=255 -> 257 words
        load_block(2, 16'hC2FF, 16'h2000);
        expect_block(16'hC2FF, 16'h2000);
        drain("max_drain");
        expect_run("max", 2, 257);

        // ofull holds off grant; mid-block toggling has no effect
        bus.ofull = 1'b1;
        load_block(5, 16'h8504, 16'h5000);
        expect_block(16'h8504, 16'h5000);
        acc = '0;
        repeat (20) begin
            @(negedge clk);
            acc |= bus.ack;
        end
        check_eq("ofull_no_ack", 32'(acc), 32'd0);
        bus.ofull = 1'b0;
        @(negedge clk);
        check_eq("ofull_release_ack", 32'(bus.ack), 32'(1 << 5));
        repeat (4) begin
            @(negedge clk);
            bus.ofull = ~bus.ofull;
        end
        drain("ofull_drain");
        expect_run("ofull", 5, 5);

        // One-word block; the leftover single word must not be granted
        put(1, 16'h8100); put(1, 16'h8101);
        sb.push_back(16'h8100);
        drain("w1_drain");
        expect_run("w1", 1, 1);
        repeat (5) @(negedge clk);
        check_eq("w1_no_regrant", 32'(grant_q.size()), 32'd0);

        // Bad header: herr, one ack, no output
        put(7, 16'h1234); put(7, 16'h8700);
        wait_ack(7, "herr_ack_timeout");
        repeat (5) @(negedge clk);
        check_eq("herr_set", 32'(bus.herr), 32'd1);
        check_eq("herr_idle_busy", 32'(bus.busy), 32'd0);
        expect_run("herr", 7, 1);

        // Reset during COPY of a 200-word block
        load_block(3, 16'h80C7, 16'h4000);
        expect_block(16'h80C7, 16'h4000);
        wait_ack(3, "rst_blk_ack_timeout");
        repeat (30) @(negedge clk);
        check_eq("pre_rst_dvalid", 32'(bus.dvalid), 32'd1);
        reset = 1'b1;
        for (int i = 0; i < NCH; i++) wr_cnt[i] = 0;
        @(negedge clk);
        check_eq("mid_rst_ack", 32'(bus.ack), 32'd0);
        check_eq("mid_rst_dvalid", 32'(bus.dvalid), 32'd0);
        check_eq("mid_rst_busy", 32'(bus.busy), 32'd0);
        check_eq("mid_rst_herr", 32'(bus.herr), 32'd0);
        reset = 1'b0;
        sb.delete();
        grant_q.delete();
        len_q.delete();
        @(negedge clk);

        // Pointer back at NCH-1: channel 2 before channel 9
        load_block(2, 16'h8201, 16'h6000);
        load_block(9, 16'h8901, 16'h9000);
        expect_block(16'h8201, 16'h6000);
        expect_block(16'h8901, 16'h9000);
        drain("ptr_drain");
        expect_run("ptr0", 2, 2);
        expect_run("ptr1", 9, 2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
